// File: rtl/mult_seq_ctrl.sv
// Purpose : iterative shift-add multiply sequencer for the EX stage (mult/multu/madd/msub).
// Latency : Start seen in IDLE at C0 -> MultValid at C0+WIDTH/STEP+2.
// Backpress: holds Stall/Bubble high while busy; Flush aborts, Reset clears the result.
// Ports   : clk/Reset (sync, active-high); Start/MultOp/OpA/OpB/HiLoIn/Flush in;
//           Stall/Bubble/Busy/MultValid/MultResult out.
module mult_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [1:0]         MultOp,
  input  logic [WIDTH-1:0]   OpA,
  input  logic [WIDTH-1:0]   OpB,
  input  logic [2*WIDTH-1:0] HiLoIn,
  input  logic               Flush,
  output logic               Stall,
  output logic               Bubble,
  output logic               Busy,
  output logic               MultValid,
  output logic [2*WIDTH-1:0] MultResult
);

  localparam int ITERS = WIDTH / STEP;
  localparam int CW    = $clog2(ITERS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;   // multiplicand, pre-shifted by count*STEP
  logic [WIDTH-1:0]     r_mplier;  // multiplier, low STEP bits are the next digit
  logic                 r_neg;
  logic [1:0]           r_op;
  logic [2*WIDTH-1:0]   r_hilo;

  logic                 w_start;
  logic                 w_signed_op;
  logic                 w_neg_a;
  logic                 w_neg_b;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [2*WIDTH-1:0]   w_pp;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_final;

  assign w_start     = Start & ~Flush;
  assign w_signed_op = (MultOp != 2'b01);
  assign w_neg_a     = w_signed_op & OpA[WIDTH-1];
  assign w_neg_b     = w_signed_op & OpB[WIDTH-1];
  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  assign w_mag_a     = w_neg_a ? (~OpA + 1'b1) : OpA;
  assign w_mag_b     = w_neg_b ? (~OpB + 1'b1) : OpB;

  // Partial product for one STEP-bit multiplier digit.
  always_comb begin
    w_pp = '0;
    for (int b = 0; b < STEP; b++) begin
      if (r_mplier[b]) begin
        w_pp = w_pp + (r_mcand << b);
      end
    end
  end

  assign w_prod = r_neg ? (~r_acc + 1'b1) : r_acc;

  always_comb begin
    case (r_op)
      2'b10:   w_final = r_hilo + w_prod;
      2'b11:   w_final = r_hilo - w_prod;
      default: w_final = w_prod;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    Stall     = 1'b0;
    Bubble    = 1'b0;
    MultValid = 1'b0;
    Busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        Stall  = w_start;
        Bubble = w_start;
        if (w_start) w_next = S_ITER;
      end
      S_ITER: begin
        if (Flush) begin
          w_next = S_IDLE;
        end else begin
          Stall  = 1'b1;
          Bubble = 1'b1;
          if (r_count == CW'(ITERS - 1)) w_next = S_FIX;
        end
      end
      S_FIX: begin
        if (Flush) begin
          w_next = S_IDLE;
        end else begin
          Stall  = 1'b1;
          Bubble = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        // Start is still high from this instruction; it is only sampled again in IDLE.
        MultValid = ~Flush;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (Reset) begin
      Stall     = 1'b0;
      Bubble    = 1'b0;
      MultValid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_count    <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_neg      <= 1'b0;
      r_op       <= 2'b00;
      r_hilo     <= '0;
      MultResult <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_neg    <= w_neg_a ^ w_neg_b;
            r_op     <= MultOp;
            r_hilo   <= HiLoIn;
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        S_ITER: begin
          if (!Flush) begin
            r_acc    <= r_acc + w_pp;
            r_mcand  <= r_mcand << STEP;
            r_mplier <= r_mplier >> STEP;
            r_count  <= r_count + 1'b1;
          end
        end
        S_FIX: begin
          if (!Flush) MultResult <= w_final;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Start4;
  logic [1:0]  MultOp;
  logic [31:0] OpA;
  logic [31:0] OpB;
  logic [63:0] HiLoIn;
  logic        Flush;
  logic        Stall, Bubble, Busy, MultValid;
  logic [63:0] MultResult;
  logic        Stall4, Bubble4, Busy4, MultValid4;
  logic [63:0] MultResult4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.WIDTH(32), .STEP(1)) dut (
    .clk(clk), .Reset(Reset), .Start(Start), .MultOp(MultOp), .OpA(OpA), .OpB(OpB),
    .HiLoIn(HiLoIn), .Flush(Flush), .Stall(Stall), .Bubble(Bubble), .Busy(Busy),
    .MultValid(MultValid), .MultResult(MultResult)
  );

  mult_seq_ctrl #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .Reset(Reset), .Start(Start4), .MultOp(MultOp), .OpA(OpA), .OpB(OpB),
    .HiLoIn(HiLoIn), .Flush(Flush), .Stall(Stall4), .Bubble(Bubble4), .Busy(Busy4),
    .MultValid(MultValid4), .MultResult(MultResult4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full operation on the STEP=1 instance with Start held until DONE.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] hilo, input logic [63:0] exp);
    int stalls = 0;
    int vals   = 0;
    int lat    = -1;
    int bmis   = 0;
    logic [63:0] res = '0;
    MultOp = op; OpA = a; OpB = b; HiLoIn = hilo; Start = 1'b1;
    #1;
    for (int i = 0; i < 45; i++) begin
      if (Stall === 1'b1) stalls++;
      if (Bubble !== Stall) bmis++;
      if (MultValid === 1'b1) begin
        vals++; lat = i; res = MultResult; Start = 1'b0;
      end
      if (i == 1) begin
        // operands are latched at C0; garbage afterwards must not matter
        OpA = ~a; OpB = a ^ b; HiLoIn = ~hilo; MultOp = ~op;
      end
      step();
    end
    Start = 1'b0;
    chk({tag, "_result"}, res, exp);
    chk({tag, "_latency"}, 64'(lat), 64'd34);
    chk({tag, "_valid_pulses"}, 64'(vals), 64'd1);
    chk({tag, "_stall_cycles"}, 64'(stalls), 64'd34);
    chk({tag, "_bubble_eq_stall"}, 64'(bmis), 64'd0);
  endtask

  initial begin
    int vals;
    int first;
    int second;
    int stalls4;
    logic [63:0] res;

    Reset = 1'b1; Start = 1'b1; Start4 = 1'b1; Flush = 1'b0;
    MultOp = 2'b00; OpA = 32'd3; OpB = 32'd5; HiLoIn = '0;
    step();
    chk("reset_stall", {63'd0, Stall}, 64'd0);
    chk("reset_bubble", {63'd0, Bubble}, 64'd0);
    step();
    chk("reset_busy", {63'd0, Busy}, 64'd0);
    chk("reset_valid", {63'd0, MultValid}, 64'd0);
    chk("reset_result", MultResult, 64'd0);
    chk("reset_busy4", {63'd0, Busy4}, 64'd0);
    Start = 1'b0; Start4 = 1'b0; Reset = 1'b0;
    step();

    run_op("mult_neg3x4", 2'b00, 32'hFFFF_FFFD, 32'd4, 64'd0, 64'hFFFF_FFFF_FFFF_FFF4);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_minneg", 2'b00, 32'h8000_0000, 32'h8000_0000, 64'd0, 64'h4000_0000_0000_0000);
    run_op("madd", 2'b10, 32'd7, 32'd6, 64'd100, 64'd142);
    run_op("msub", 2'b11, 32'd1, 32'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);

    // Flush in ITER (count 10)
    MultOp = 2'b01; OpA = 32'd5; OpB = 32'd5; Start = 1'b1;
    #1;
    repeat (11) step();
    chk("flush_busy_before", {63'd0, Busy}, 64'd1);
    Flush = 1'b1; Start = 1'b0;
    #1;
    chk("flush_stall_same", {63'd0, Stall}, 64'd0);
    chk("flush_bubble_same", {63'd0, Bubble}, 64'd0);
    step();
    Flush = 1'b0;
    #1;
    chk("flush_busy_next", {63'd0, Busy}, 64'd0);
    chk("flush_stall_next", {63'd0, Stall}, 64'd0);
    vals = 0;
    for (int i = 0; i < 40; i++) begin
      if (MultValid === 1'b1) vals++;
      step();
    end
    chk("flush_no_valid", 64'(vals), 64'd0);
    chk("flush_result_kept", MultResult, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("after_flush", 2'b01, 32'd5, 32'd5, 64'd0, 64'd25);

    // Flush in DONE suppresses the strobe; result was already registered in FIX
    MultOp = 2'b10; OpA = 32'd2; OpB = 32'd3; HiLoIn = 64'd1; Start = 1'b1;
    #1;
    repeat (34) step();
    chk("done_flush_busy", {63'd0, Busy}, 64'd1);
    Flush = 1'b1; Start = 1'b0;
    #1;
    chk("done_flush_valid", {63'd0, MultValid}, 64'd0);
    chk("done_flush_result", MultResult, 64'd7);
    step();
    Flush = 1'b0;
    #1;
    chk("done_flush_idle", {63'd0, Busy}, 64'd0);

    // Reset in ITER (count 20)
    MultOp = 2'b00; OpA = 32'd7; OpB = 32'd9; Start = 1'b1;
    #1;
    repeat (21) step();
    Reset = 1'b1; Start = 1'b0;
    #1;
    chk("rst_mid_stall", {63'd0, Stall}, 64'd0);
    step();
    chk("rst_mid_busy", {63'd0, Busy}, 64'd0);
    chk("rst_mid_result", MultResult, 64'd0);
    Reset = 1'b0;
    vals = 0;
    for (int i = 0; i < 40; i++) begin
      if (MultValid === 1'b1) vals++;
      step();
    end
    chk("rst_mid_no_valid", 64'(vals), 64'd0);

    // Back-to-back: Start held continuously
    MultOp = 2'b00; OpA = 32'hFFFF_FFFE; OpB = 32'd3; Start = 1'b1;
    #1;
    vals = 0; first = -1; second = -1; res = '0;
    for (int i = 0; i < 100; i++) begin
      if (MultValid === 1'b1) begin
        vals++;
        if (first < 0) first = i;
        else begin
          second = i; res = MultResult; Start = 1'b0;
        end
      end
      step();
    end
    Start = 1'b0;
    chk("b2b_first", 64'(first), 64'd34);
    chk("b2b_gap", 64'(second - first), 64'd35);
    chk("b2b_pulses", 64'(vals), 64'd2);
    chk("b2b_result", res, 64'hFFFF_FFFF_FFFF_FFFA);

    // STEP=4 instance
    MultOp = 2'b00; OpA = 32'd3; OpB = 32'd5; Start4 = 1'b1;
    #1;
    vals = 0; first = -1; stalls4 = 0; res = '0;
    for (int i = 0; i < 20; i++) begin
      if (Stall4 === 1'b1) stalls4++;
      if (MultValid4 === 1'b1) begin
        vals++; first = i; res = MultResult4; Start4 = 1'b0;
      end
      step();
    end
    Start4 = 1'b0;
    chk("step4_latency", 64'(first), 64'd10);
    chk("step4_result", res, 64'd15);
    chk("step4_pulses", 64'(vals), 64'd1);
    chk("step4_stalls", 64'(stalls4), 64'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Multi-cycle multiply sequencer for the EX stage. It accepts a multiply-class instruction held in ID/EX and computes the 64-bit product with an iterative shift-add datapath. While it runs, it freezes the upstream pipeline and feeds bubbles into EX/MEM. On completion it presents the 64-bit result with a one-cycle valid, which drives the EX/MEM multiply-result, MultBit and HiLoWrite inputs.

Parameters:
WIDTH, 32, operand width in bits.
STEP, 1, multiplier bits retired per iteration; legal values are 1, 2 and 4 (must divide WIDTH).

Ports:
clk  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
Start  in  1  multiply instruction valid in ID/EX (level; held by the stall)
MultOp  in  2  00 mult (signed), 01 multu, 10 madd (signed, HiLo + product), 11 msub (signed, HiLo − product)
OpA  in  WIDTH  rs operand
OpB  in  WIDTH  rt operand
HiLoIn  in  2*WIDTH  current {Hi,Lo}, used by madd/msub
Flush  in  1  branch/exception flush; kills an in-flight operation
Stall  out  1  freeze PC, IF/ID and ID/EX
Bubble  out  1  force EX/MEM control inputs (RegWrite, MemWrite, MemRead, Branch, HiLoWrite, MultBit) to 0
Busy  out  1  state is not IDLE
MultValid  out  1  one-cycle completion strobe → EX/MEM MultBitIn and HiLoWriteIn
MultResult  out  2*WIDTH  final {Hi,Lo} → EX/MEM MultResultIn

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (Reset).
- Reset values: state=IDLE; count=0; MultResult=0; MultValid=0; Busy=0. Stall and Bubble are 0 while Reset is high.
- States: IDLE, ITER, FIX, DONE. ITERS = WIDTH/STEP.
- IDLE:
  - If Start=1 and Flush=0, latch |OpA|, |OpB| (magnitudes only for signed ops), the result sign (XOR of operand MSBs, signed ops only), MultOp and HiLoIn.
  - Clear the accumulator and count, then go to ITER.
  - Stall=Bubble=Start&~Flush, combinational in this cycle.
- ITER:
  - Each cycle, add (multiplicand << (count*STEP)) × (next STEP multiplier bits) to the 2*WIDTH accumulator, then count++.
  - After count reaches ITERS−1, go to FIX.
- FIX:
  - Negate the accumulator if the sign bit is set (two's complement over 2*WIDTH).
  - madd: result = HiLoIn + product. msub: result = HiLoIn − product. Both are modulo 2^(2*WIDTH), with no overflow flag.
  - Register the value into MultResult, then go to DONE.
- DONE: MultValid=1, Stall=0, Bubble=0. ID/EX advances and EX/MEM captures MultResult together with the instruction's own controls. Next state is IDLE unconditionally.
- Start is ignored in DONE. It is still high from the completing instruction; a new Start is sampled only in IDLE.
- Stall and Bubble are 1 throughout ITER and FIX.
- Latency: Start seen in IDLE at cycle C0 → MultValid at C0+ITERS+2. Stall is high for ITERS+2 cycles (34 at defaults).
- MultResult holds its value until the next FIX. It is not cleared at DONE.
- Flush:
  - Flush in ITER or FIX forces IDLE on the next edge, with no MultValid and MultResult unchanged. Stall=Bubble=0 in that same cycle so the flush can propagate.
  - Flush in DONE suppresses MultValid that cycle.
- Reset mid-operation: IDLE on the next edge, no MultValid, MultResult=0.
- Operand changes during ITER and FIX are ignored; all operands are latched at C0.
- Back-to-back multiplies: the second Start is first seen in IDLE one cycle after DONE, so a minimum of ITERS+3 cycles separates the two MultValid strobes.
- Signed edge case: 0x80000000 × 0x80000000 gives magnitude 2^31 × 2^31 = 0x40000000_00000000, with the sign positive.

Test Plan:
- mult: OpA=0xFFFFFFFD (−3), OpB=4, Start held → Stall high exactly 34 cycles; one MultValid pulse; MultResult=0xFFFFFFFF_FFFFFFF4.
- multu: OpA=OpB=0xFFFFFFFF → MultResult=0xFFFFFFFE_00000001. mult with OpA=OpB=0x80000000 → 0x40000000_00000000.
- madd: HiLoIn=100, OpA=7, OpB=6 → 142 (0x8E). msub: HiLoIn=0, OpA=1, OpB=1 → 0xFFFFFFFF_FFFFFFFF.
- Flush asserted at ITER cycle 10 → Busy=0 and Stall=0 on the next cycle; no MultValid; MultResult keeps its previous value. A fresh Start afterwards completes normally.
- Reset asserted at ITER cycle 20 → next cycle IDLE, MultResult=0, no MultValid. Start held through DONE → exactly one MultValid; a second Start one cycle later starts a new operation, with strobes 35 cycles apart.
- STEP=4 build: 3×5 → MultValid at C0+10, MultResult=15.
